// File: rtl/instr_decode_if.sv
// Fetch-to-decode-to-register-file handshake bundle.
// The master side offers instructions and consumes decoded fields; the slave side is the decoder.
interface instr_decode_if #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 4
);
    logic [DATA_W-1:0] I_instr;
    logic              I_instr_valid;
    logic              o_instr_ready;
    logic              o_dec_valid;
    logic              I_dec_ready;
    logic [SEL_W-1:0]  o_selA;
    logic [SEL_W-1:0]  o_selB;
    logic [SEL_W-1:0]  o_selD;
    logic              o_we;
    logic [3:0]        o_aluop;
    logic              o_flag;
    logic [DATA_W-1:0] o_imm;
    logic              o_illegal;

    modport master (
        output I_instr, I_instr_valid, I_dec_ready,
        input  o_instr_ready, o_dec_valid, o_selA, o_selB, o_selD,
               o_we, o_aluop, o_flag, o_imm, o_illegal
    );

    modport slave (
        input  I_instr, I_instr_valid, I_dec_ready,
        output o_instr_ready, o_dec_valid, o_selA, o_selB, o_selD,
               o_we, o_aluop, o_flag, o_imm, o_illegal
    );
endinterface

// File: rtl/instr_decode.sv
// Instruction decode stage with a 2-entry skid buffer (main + skid) holding pre-decoded fields.
// Fetch-side ready is a pure register output; decoded outputs come straight from the main entry.
module instr_decode #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 4
) (
    input  logic           I_clk,
    input  logic           I_rst_n,
    input  logic           I_flush,
    instr_decode_if.slave  bus
);
    typedef struct packed {
        logic [2:0] sel_a;
        logic [2:0] sel_b;
        logic [2:0] sel_d;
        logic       we;
        logic [3:0] aluop;
        logic       flag;
        logic [7:0] imm;
        logic       illegal;
    } dec_t;

    function automatic dec_t decode(input logic [DATA_W-1:0] instr);
        dec_t d;
        d.aluop   = instr[15:12];
        d.sel_d   = instr[11:9];
        d.flag    = instr[8];
        d.sel_a   = instr[7:5];
        d.sel_b   = instr[4:2];
        d.imm     = instr[7:0];
        d.illegal = (instr[15:12] >= 4'd14);
        // STORE, JMP, JMPEQ and the reserved codes never write a destination
        d.we      = (instr[15:12] <= 4'd6) ||
                    ((instr[15:12] >= 4'd8) && (instr[15:12] <= 4'd11));
        return d;
    endfunction

    dec_t main_reg, main_next;
    dec_t skid_reg, skid_next;
    logic main_valid_reg, main_valid_next;
    logic skid_valid_reg, skid_valid_next;
    dec_t incoming;
    logic accept;
    logic consume;

    assign incoming = decode(bus.I_instr);
    assign accept   = bus.I_instr_valid & ~skid_valid_reg;
    assign consume  = main_valid_reg & bus.I_dec_ready;

    always_comb begin
        main_next       = main_reg;
        skid_next       = skid_reg;
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        if (I_flush) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (main_valid_reg && !consume) begin
            // Main is stalled: an accepted word parks in the skid entry
            if (accept) begin
                skid_next       = incoming;
                skid_valid_next = 1'b1;
            end
        end else if (skid_valid_reg) begin
            main_next       = skid_reg;
            main_valid_next = 1'b1;
            skid_valid_next = 1'b0;
        end else if (accept) begin
            main_next       = incoming;
            main_valid_next = 1'b1;
        end else begin
            main_valid_next = 1'b0;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else begin
            main_reg       <= main_next;
            skid_reg       <= skid_next;
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
        end
    end

    assign bus.o_instr_ready = ~skid_valid_reg;
    assign bus.o_dec_valid   = main_valid_reg;
    assign bus.o_selA        = {{(SEL_W-3){1'b0}}, main_reg.sel_a};
    assign bus.o_selB        = {{(SEL_W-3){1'b0}}, main_reg.sel_b};
    assign bus.o_selD        = {{(SEL_W-3){1'b0}}, main_reg.sel_d};
    assign bus.o_we          = main_reg.we;
    assign bus.o_aluop       = main_reg.aluop;
    assign bus.o_flag        = main_reg.flag;
    assign bus.o_imm         = {{(DATA_W-8){1'b0}}, main_reg.imm};
    assign bus.o_illegal     = main_reg.illegal;
endmodule

// File: tb/tb_instr_decode.sv
// Bench for instr_decode: directed steps then random traffic, checked against a queue-based
// model where the two buffer entries are simply the first two slots of an instruction FIFO.
module tb_instr_decode;
    localparam int DATA_W = 16;
    localparam int SEL_W  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    instr_decode_if #(.DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

    instr_decode #(.DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .I_clk   (clk),
        .I_rst_n (rst_n),
        .I_flush (flush),
        .bus     (bus)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] q[$];
    logic [15:0] we_table = 16'h0F7F;   // bit n set => opcode n writes rD
    logic        last_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_fields(input logic [15:0] x);
        int unsigned v;
        int unsigned op;
        v  = 32'(x);
        op = v / 4096;
        check("aluop",   32'(bus.o_aluop),   op);
        check("selD",    32'(bus.o_selD),    (v / 512) % 8);
        check("flag",    32'(bus.o_flag),    (v / 256) % 2);
        check("selA",    32'(bus.o_selA),    (v / 32) % 8);
        check("selB",    32'(bus.o_selB),    (v / 4) % 8);
        check("imm",     32'(bus.o_imm),     v % 256);
        check("illegal", 32'(bus.o_illegal), (op >= 14) ? 1 : 0);
        check("we",      32'(bus.o_we),      32'(we_table[op[3:0]]));
    endtask

    // One clock of traffic: drive at the falling edge, check model state, advance the model.
    task automatic step(input logic [15:0] instr, input logic vld, input logic drdy, input logic fl);
        logic exp_ready;
        @(negedge clk);
        bus.I_instr       = instr;
        bus.I_instr_valid = vld;
        bus.I_dec_ready   = drdy;
        flush             = fl;
        exp_ready = (q.size() < 2);
        check("instr_ready", 32'(bus.o_instr_ready), 32'(exp_ready));
        check("dec_valid",   32'(bus.o_dec_valid),   (q.size() > 0) ? 1 : 0);
        if (q.size() > 0) check_fields(q[0]);
        last_acc = vld && exp_ready && !fl;
        if (fl) begin
            $display("t=%0t flush (%0d buffered dropped)", $time, q.size());
            q.delete();
        end else begin
            if (q.size() > 0 && drdy) begin
                $display("t=%0t out 0x%04h", $time, q[0]);
                void'(q.pop_front());
            end
            if (last_acc) begin
                $display("t=%0t in  0x%04h", $time, instr);
                q.push_back(instr);
            end
        end
    endtask

    initial begin
        logic [15:0] cur;
        logic        cur_v;
        logic        fl;
        logic        pick_new;

        bus.I_instr       = '0;
        bus.I_instr_valid = 1'b0;
        bus.I_dec_ready   = 1'b0;
        last_acc          = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_dec_valid", 32'(bus.o_dec_valid), 0);
        check("rst_aluop",     32'(bus.o_aluop),     0);
        check("rst_imm",       32'(bus.o_imm),       0);
        check("rst_selD",      32'(bus.o_selD),      0);
        check("rst_we",        32'(bus.o_we),        0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single SUB with explicit expected fields
        step(16'h1A24, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("t1_valid", 32'(bus.o_dec_valid), 1);
        check("t1_aluop", 32'(bus.o_aluop),     1);
        check("t1_selD",  32'(bus.o_selD),      5);
        check("t1_selA",  32'(bus.o_selA),      1);
        check("t1_selB",  32'(bus.o_selB),      1);
        check("t1_we",    32'(bus.o_we),        1);
        check("t1_imm",   32'(bus.o_imm),       32'h24);

        // Back-to-back stream
        step(16'h0000, 1'b1, 1'b1, 1'b0);
        step(16'h7E00, 1'b1, 1'b1, 1'b0);
        step(16'hC0FF, 1'b1, 1'b1, 1'b0);
        step(16'h0000, 1'b0, 1'b1, 1'b0);
        step(16'h0000, 1'b0, 1'b1, 1'b0);

        // Stall: A to main, B to skid, C held by fetch until accepted
        step(16'h2000, 1'b1, 1'b0, 1'b0);
        step(16'h3000, 1'b1, 1'b0, 1'b0);
        step(16'h4000, 1'b1, 1'b0, 1'b0);
        step(16'h4000, 1'b1, 1'b0, 1'b0);
        step(16'h4000, 1'b1, 1'b1, 1'b0);
        step(16'h4000, 1'b1, 1'b1, 1'b0);
        step(16'h0000, 1'b0, 1'b1, 1'b0);
        step(16'h0000, 1'b0, 1'b1, 1'b0);

        // Reserved opcodes
        step(16'hE123, 1'b1, 1'b1, 1'b0);
        step(16'hF000, 1'b1, 1'b1, 1'b0);
        step(16'h0000, 1'b0, 1'b1, 1'b0);
        step(16'h0000, 1'b0, 1'b1, 1'b0);

        // Flush with both entries full and a concurrent offer
        step(16'h5111, 1'b1, 1'b0, 1'b0);
        step(16'h6222, 1'b1, 1'b0, 1'b0);
        step(16'h9333, 1'b1, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b1, 1'b0);
        step(16'hB2A8, 1'b1, 1'b1, 1'b0);
        step(16'h0000, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset between edges
        step(16'h8001, 1'b1, 1'b1, 1'b0);
        step(16'h8002, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        bus.I_instr_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_dec_valid", 32'(bus.o_dec_valid),   0);
        check("arst_ready",     32'(bus.o_instr_ready), 1);
        check("arst_aluop",     32'(bus.o_aluop),       0);
        check("arst_selA",      32'(bus.o_selA),        0);
        check("arst_imm",       32'(bus.o_imm),         0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(16'hA0C4, 1'b1, 1'b1, 1'b0);
        step(16'h0000, 1'b0, 1'b1, 1'b0);
        step(16'h0000, 1'b0, 1'b1, 1'b0);

        // Random traffic; fetch holds an unaccepted offer until it is taken or flushed
        cur      = '0;
        cur_v    = 1'b0;
        pick_new = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (pick_new) begin
                cur   = 16'($urandom);
                cur_v = ($urandom_range(0, 3) != 0);
            end
            fl = ($urandom_range(0, 24) == 0);
            step(cur, cur_v, ($urandom_range(0, 2) != 0), fl);
            pick_new = last_acc || fl || !cur_v;
        end
        for (int i = 0; i < 4; i++) step(16'h0000, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
